// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults and FSM state encoding for mac_accum_requant.
`timescale 1ns/1ps
package mac_pkg;

  localparam int DEF_ACC_W = 32;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_LEN_W = 16;

  // ACC: taking product beats, REQ: requantizing, OUT: presenting the result.
  typedef enum logic [1:0] {
    ACC = 2'd0,
    REQ = 2'd1,
    OUT = 2'd2
  } state_t;

endpackage

// File: rtl/requant_sat.sv
// requant_sat: round-half-up arithmetic right shift of the accumulator,
// optional ReLU (MAC_ACCUM_RELU_EN), then signed saturation to OUT_W bits.
// Purely combinational; the caller registers the result.
`timescale 1ns/1ps
module requant_sat
  import mac_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [4:0]       shift_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    sat_o
);

  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

  // One extra bit keeps acc + 2^(shift-1) from wrapping at the top of range.
  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] half;
  logic signed [ACC_W:0] rnd;

  // Round, optionally clip negatives, then clamp to the output range.
  always_comb begin
    ext  = {acc_i[ACC_W-1], acc_i};
    half = '0;
    if (shift_i != 5'd0) begin
      half = (ACC_W+1)'(1) << (shift_i - 5'd1);
    end
    rnd = (ext + half) >>> shift_i;
`ifdef MAC_ACCUM_RELU_EN
    if (rnd[ACC_W]) begin
      rnd = '0;
    end
`endif
    sat_o  = 1'b0;
    data_o = rnd[OUT_W-1:0];
    if (rnd > MAX_V) begin
      data_o = MAX_V[OUT_W-1:0];
      sat_o  = 1'b1;
    end else if (rnd < MIN_V) begin
      data_o = MIN_V[OUT_W-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/mac_accum_requant.sv
// mac_accum_requant: accumulates cfg_len signed products (plus a bias) with
// saturation, requantizes the sum to OUT_W bits and hands it downstream.
// Optional feature: define MAC_ACCUM_RELU_EN to clip negative results to 0.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid-side signals hold their values until that transfer.
// Timing: last beat accepted at edge t -> result registered at t+1 (REQ),
// out_valid rises at t+2 (output register stage in OUT).
`timescale 1ns/1ps
module mac_accum_requant
  import mac_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [4:0]       cfg_shift,
  input  logic [ACC_W-1:0] cfg_bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output state_t           dbg_state
);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [LEN_W-1:0]  cnt_q, cnt_d;
  logic        [LEN_W-1:0]  len_q, len_d;
  logic        [4:0]        shift_q, shift_d;
  logic        [ACC_W-1:0]  bias_q, bias_d;
  logic                     gsat_q, gsat_d;
  logic                     out_valid_q, out_valid_d;
  logic        [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic signed [OUT_W-1:0]  rq_data;
  logic                     rq_sat;
  logic        [LEN_W-1:0]  len_in;
  logic signed [ACC_W-1:0]  add_a;
  logic signed [ACC_W-1:0]  sum;
  logic                     ov;
  logic                     last;

  // Saturating signed add; returns {overflowed, clamped sum}.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}}
                      : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  requant_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_requant (
    .acc_i   (acc_q),
    .shift_i (shift_q),
    .data_o  (rq_data),
    .sat_o   (rq_sat)
  );

  assign in_ready  = (state_q == ACC);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign dbg_state = state_q;

  // Next-state logic: group accumulation, requant capture, output handshake.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    shift_d     = shift_q;
    bias_d      = bias_q;
    gsat_d      = gsat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    len_in      = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    add_a       = (cnt_q == '0) ? cfg_bias : acc_q;
    {ov, sum}   = sat_add(add_a, in_data);
    last        = 1'b0;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = sum;
          if (cnt_q == '0) begin
            // First beat of a group: config is sampled here and nowhere else.
            len_d   = len_in;
            shift_d = cfg_shift;
            bias_d  = cfg_bias;
            gsat_d  = ov;
            last    = (len_in == LEN_W'(1));
          end else begin
            gsat_d = gsat_q | ov;
            last   = ((cnt_q + LEN_W'(1)) == len_q);
          end
          if (last) begin
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      REQ: begin
        out_data_d = rq_data;
        out_sat_d  = gsat_q | rq_sat;
        state_d    = OUT;
      end
      OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State registers; reset drops any partial or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      bias_q      <= '0;
      gsat_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      bias_q      <= bias_d;
      gsat_q      <= gsat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_mac_accum_requant.sv
// tb_mac_accum_requant: table-driven bench for mac_accum_requant with an
// expected-result queue, latency/backpressure/reset sequences.
`timescale 1ns/1ps
module tb_mac_accum_requant;
  import mac_pkg::*;

`ifdef MAC_ACCUM_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_len;
  logic [4:0]  cfg_shift;
  logic [31:0] cfg_bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sat;
  state_t      dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    int               len;
    int               shift;
    int               bias;
    int               n;
    logic [3:0][31:0] p;
    logic [8:0]       exp;
  } vec_t;

  vec_t vecs[11];

  mac_accum_requant dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .cfg_bias  (cfg_bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int len, input int shift, input int bias, input int n,
                              input int a, input int b, input int c, input int d,
                              input bit es, input logic [7:0] ed);
    vec_t v;
    v.len = len; v.shift = shift; v.bias = bias; v.n = n;
    v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
    v.exp = {es, ed};
    return v;
  endfunction

  // Drive one beat and wait (bounded) for it to be accepted.
  task automatic send_beat(input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // One full group: beats, latency, result, optional hold or reset in OUT.
  task automatic run_group(input int len, input int shift, input int bias, input int n,
                           input logic [3:0][31:0] p, input logic [8:0] exp,
                           input int hold, input bit kill);
    logic [8:0] e;
    exp_q.push_back(exp);
    out_ready = (hold == 0) && !kill;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i == 0) begin
        cfg_len   = len[15:0];
        cfg_shift = shift[4:0];
        cfg_bias  = bias;
      end
      send_beat(p[i]);
      if (i == 0) begin
        cfg_len   = 16'($urandom_range(0, 3));
        cfg_shift = 5'($urandom);
        cfg_bias  = $urandom;
      end
    end
    @(negedge clk);
    check("lat_t1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_t2_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_t3_valid", {31'd0, out_valid}, 32'd1);
    check("out_in_ready", {31'd0, in_ready}, 32'd0);
    e = exp_q.pop_front();
    check("result", {23'd0, out_sat, out_data}, {23'd0, e});
    if (kill) begin
      rst = 1'b1;
      #1;
      check("kill_valid", {31'd0, out_valid}, 32'd0);
      check("kill_data", {23'd0, out_sat, out_data}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_result", {23'd0, out_sat, out_data}, {23'd0, e});
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_valid_drop", {31'd0, out_valid}, 32'd0);
    check("hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Main test sequence.
  initial begin
    logic [3:0][31:0] p7;
    rst       = 1'b1;
    cfg_len   = '0;
    cfg_shift = '0;
    cfg_bias  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    vecs[0]  = mk(4, 0, 0, 4, 10, 20, 30, 40, 1'b0, 8'd100);
    vecs[1]  = mk(2, 2, 1, 2, 5, 0, 0, 0, 1'b0, 8'd2);
    vecs[2]  = mk(1, 0, 0, 1, 1000, 0, 0, 0, 1'b1, 8'd127);
    vecs[3]  = mk(1, 0, 0, 1, -1000, 0, 0, 0, !RELU, RELU ? 8'h00 : 8'h80);
    vecs[4]  = mk(2, 0, 0, 2, 32'h7fff_ffff, 1, 0, 0, 1'b1, 8'd127);
    vecs[5]  = mk(0, 0, 0, 1, 5, 0, 0, 0, 1'b0, 8'd5);
    vecs[6]  = mk(1, 1, 0, 1, -3, 0, 0, 0, 1'b0, RELU ? 8'h00 : 8'hff);
    vecs[7]  = mk(3, 4, -8, 3, 16, 16, 16, 0, 1'b0, 8'd3);
    vecs[8]  = mk(2, 31, 0, 2, 32'h8000_0000, -1, 0, 0, 1'b1, RELU ? 8'h00 : 8'hff);
    vecs[9]  = mk(1, 31, 0, 1, 32'h7fff_ffff, 0, 0, 0, 1'b0, 8'd1);
    vecs[10] = mk(2, 0, 0, 2, -50, 20, 0, 0, 1'b0, RELU ? 8'h00 : 8'he2);

    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_group(vecs[i].len, vecs[i].shift, vecs[i].bias, vecs[i].n,
                vecs[i].p, vecs[i].exp, 0, 1'b0);
    end

    // Backpressure: result held for 5 cycles, then next group right away.
    run_group(vecs[0].len, vecs[0].shift, vecs[0].bias, vecs[0].n,
              vecs[0].p, vecs[0].exp, 5, 1'b0);
    run_group(vecs[1].len, vecs[1].shift, vecs[1].bias, vecs[1].n,
              vecs[1].p, vecs[1].exp, 0, 1'b0);

    // Reset while the result is pending in OUT.
    run_group(vecs[7].len, vecs[7].shift, vecs[7].bias, vecs[7].n,
              vecs[7].p, vecs[7].exp, 0, 1'b1);

    // Reset after 2 of 4 beats: nothing emitted, then a fresh group.
    cfg_len = 16'd4; cfg_shift = '0; cfg_bias = '0;
    send_beat(32'd100);
    send_beat(32'd200);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midgrp_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("midgrp_no_valid", {31'd0, out_valid}, 32'd0);
    end
    p7 = '0;
    p7[0] = 32'd7;
    run_group(1, 0, 0, 1, p7, {1'b0, 8'd7}, 0, 1'b0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
